// File: rtl/dvfs_transition_sequencer.sv
// rtl/dvfs_transition_sequencer.sv - orders voltage/frequency operating-point transitions
module dvfs_transition_sequencer #(
    parameter int LEVEL_W       = 3,
    parameter int RESET_LEVEL   = 4,
    parameter int THERMAL_LEVEL = 1,
    parameter int SETTLE_CYCLES = 64,
    parameter int ACK_TIMEOUT   = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [LEVEL_W-1:0] req_voltage_level,
    input  logic [LEVEL_W-1:0] req_freq_level,
    input  logic               thermal_alert,
    output logic [LEVEL_W-1:0] vreg_level,
    output logic               vreg_update,
    input  logic               vreg_ack,
    output logic [LEVEL_W-1:0] freq_level,
    output logic               freq_update,
    input  logic               freq_ack,
    output logic               busy,
    output logic               done,
    output logic               fault,
    input  logic               fault_clear
);

    localparam logic [LEVEL_W-1:0] RST_LVL   = LEVEL_W'(RESET_LEVEL);
    localparam logic [LEVEL_W-1:0] THERM_LVL = LEVEL_W'(THERMAL_LEVEL);
    localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
    localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);
    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_VUP,
        S_VUP_WAIT,
        S_VUP_SETTLE,
        S_FREQ,
        S_FREQ_WAIT,
        S_VDN,
        S_VDN_WAIT,
        S_VDN_SETTLE,
        S_DONE,
        S_FAULT
    } state_t;

    state_t              state, state_n;
    logic [LEVEL_W-1:0]  tgt_v, tgt_v_n;
    logic [LEVEL_W-1:0]  tgt_f, tgt_f_n;
    logic [LEVEL_W-1:0]  req_tgt_v;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [SET_W-1:0]    settle_cnt;
    logic                thermal_pending;
    logic                thermal_q;
    logic                pending_clr;
    logic                in_wait;
    logic                in_settle;

    // Voltage first when going up, frequency first when going down.
    function automatic state_t route(input logic [LEVEL_W-1:0] tv, input logic [LEVEL_W-1:0] tf,
                                     input logic [LEVEL_W-1:0] cv, input logic [LEVEL_W-1:0] cf);
        if (tv > cv)
            return S_VUP;
        else if (tf != cf)
            return S_FREQ;
        else if (tv < cv)
            return S_VDN;
        else
            return S_DONE;
    endfunction

    assign req_tgt_v = (req_voltage_level > req_freq_level) ? req_voltage_level : req_freq_level;

    assign fault       = (state == S_FAULT);
    assign busy        = (state != S_IDLE);
    assign req_ready   = (state == S_IDLE) & !fault & !thermal_alert & !thermal_pending;
    assign vreg_update = (state == S_VUP) | (state == S_VDN);
    assign freq_update = (state == S_FREQ);
    assign in_wait     = (state == S_VUP_WAIT) | (state == S_FREQ_WAIT) | (state == S_VDN_WAIT);
    assign in_settle   = (state == S_VUP_SETTLE) | (state == S_VDN_SETTLE);

    always_comb begin
        state_n     = state;
        tgt_v_n     = tgt_v;
        tgt_f_n     = tgt_f;
        pending_clr = 1'b0;
        case (state)
            S_IDLE: begin
                if (thermal_alert | thermal_pending) begin
                    pending_clr = 1'b1;
                    // Already at or below the thermal point: nothing to do.
                    if (!((vreg_level <= THERM_LVL) && (freq_level <= THERM_LVL))) begin
                        tgt_v_n = THERM_LVL;
                        tgt_f_n = THERM_LVL;
                        state_n = route(THERM_LVL, THERM_LVL, vreg_level, freq_level);
                    end
                end else if (req_valid) begin
                    tgt_v_n = req_tgt_v;
                    tgt_f_n = req_freq_level;
                    state_n = route(req_tgt_v, req_freq_level, vreg_level, freq_level);
                end
            end
            S_VUP: state_n = S_VUP_WAIT;
            S_VUP_WAIT: begin
                if (vreg_ack)
                    state_n = S_VUP_SETTLE;
                else if (wait_cnt == WAIT_LAST)
                    state_n = S_FAULT;
            end
            S_VUP_SETTLE: begin
                if (settle_cnt == SET_LAST)
                    state_n = (tgt_f != freq_level) ? S_FREQ : S_DONE;
            end
            S_FREQ: state_n = S_FREQ_WAIT;
            S_FREQ_WAIT: begin
                if (freq_ack)
                    state_n = (tgt_v < vreg_level) ? S_VDN : S_DONE;
                else if (wait_cnt == WAIT_LAST)
                    state_n = S_FAULT;
            end
            S_VDN: state_n = S_VDN_WAIT;
            S_VDN_WAIT: begin
                if (vreg_ack)
                    state_n = S_VDN_SETTLE;
                else if (wait_cnt == WAIT_LAST)
                    state_n = S_FAULT;
            end
            S_VDN_SETTLE: begin
                if (settle_cnt == SET_LAST)
                    state_n = S_DONE;
            end
            S_DONE: state_n = S_IDLE;
            S_FAULT: begin
                if (fault_clear)
                    state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            tgt_v           <= RST_LVL;
            tgt_f           <= RST_LVL;
            vreg_level      <= RST_LVL;
            freq_level      <= RST_LVL;
            wait_cnt        <= '0;
            settle_cnt      <= '0;
            thermal_pending <= 1'b0;
            thermal_q       <= 1'b0;
            done            <= 1'b0;
        end else begin
            state     <= state_n;
            tgt_v     <= tgt_v_n;
            tgt_f     <= tgt_f_n;
            thermal_q <= thermal_alert;
            done      <= (state == S_DONE);

            if ((state_n == S_VUP) || (state_n == S_VDN))
                vreg_level <= tgt_v_n;
            if (state_n == S_FREQ)
                freq_level <= tgt_f_n;

            // Counters run only while staying in the same wait/settle state.
            if (in_wait && (state_n == state))
                wait_cnt <= wait_cnt + WAIT_W'(1);
            else
                wait_cnt <= '0;
            if (in_settle && (state_n == state))
                settle_cnt <= settle_cnt + SET_W'(1);
            else
                settle_cnt <= '0;

            if (pending_clr)
                thermal_pending <= 1'b0;
            else if (busy && thermal_alert && !thermal_q)
                thermal_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dvfs_transition_sequencer.sv
// tb/tb_dvfs_transition_sequencer.sv - scoreboard bench for dvfs_transition_sequencer
module tb_dvfs_transition_sequencer;

    localparam int LW    = 3;
    localparam int EV_V  = 0;
    localparam int EV_F  = 1;
    localparam int EV_D  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [LW-1:0] req_voltage_level;
    logic [LW-1:0] req_freq_level;
    logic          thermal_alert;
    logic [LW-1:0] vreg_level;
    logic          vreg_update;
    logic          vreg_ack;
    logic [LW-1:0] freq_level;
    logic          freq_update;
    logic          freq_ack;
    logic          busy;
    logic          done;
    logic          fault;
    logic          fault_clear;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int kind;
        int level;
        int at;
    } ev_t;
    ev_t evq[$];

    dvfs_transition_sequencer dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_voltage_level (req_voltage_level),
        .req_freq_level    (req_freq_level),
        .thermal_alert     (thermal_alert),
        .vreg_level        (vreg_level),
        .vreg_update       (vreg_update),
        .vreg_ack          (vreg_ack),
        .freq_level        (freq_level),
        .freq_update       (freq_update),
        .freq_ack          (freq_ack),
        .busy              (busy),
        .done              (done),
        .fault             (fault),
        .fault_clear       (fault_clear)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input int level, input int at);
        ev_t e;
        e.kind  = kind;
        e.level = level;
        e.at    = at;
        evq.push_back(e);
    endtask

    task automatic observe(input int kind, input int level);
        ev_t e;
        check("ev_expected", int'(evq.size() > 0), 1);
        if (evq.size() > 0) begin
            e = evq.pop_front();
            check("ev_kind", kind, e.kind);
            check("ev_level", level, e.level);
            check("ev_cycle", cyc, e.at);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (vreg_update) observe(EV_V, int'(vreg_level));
            if (freq_update) observe(EV_F, int'(freq_level));
            if (done)        observe(EV_D, 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic issue(input int v, input int f);
        req_valid         = 1'b1;
        req_voltage_level = LW'(v);
        req_freq_level    = LW'(f);
        check("ready_at_accept", int'(req_ready), 1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic pulse_vack(input int at);
        wait_until(at);
        vreg_ack = 1'b1;
        step();
        vreg_ack = 1'b0;
    endtask

    task automatic pulse_fack(input int at);
        wait_until(at);
        freq_ack = 1'b1;
        step();
        freq_ack = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (evq.size() > 0 && n < budget) begin
            step();
            n++;
        end
        step();
        check(tag, int'(evq.size()), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        check("rst_vreg", int'(vreg_level), 4);
        check("rst_freq", int'(freq_level), 4);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        step();
    endtask

    initial begin
        int c0;
        rst               = 1'b1;
        req_valid         = 1'b0;
        req_voltage_level = '0;
        req_freq_level    = '0;
        thermal_alert     = 1'b0;
        vreg_ack          = 1'b0;
        freq_ack          = 1'b0;
        fault_clear       = 1'b0;
        step();
        step();
        check("reset_vreg", int'(vreg_level), 4);
        check("reset_freq", int'(freq_level), 4);
        check("reset_upd", int'(vreg_update | freq_update), 0);
        check("reset_done", int'(done), 0);
        check("reset_fault", int'(fault), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_ready", int'(req_ready), 1);
        rst = 1'b0;
        step();

        // raise 4/4 -> 6/6
        c0 = cyc;
        expect_ev(EV_V, 6, c0 + 1);
        expect_ev(EV_F, 6, c0 + 70);
        expect_ev(EV_D, 0, c0 + 75);
        issue(6, 6);
        pulse_vack(c0 + 5);
        pulse_fack(c0 + 73);
        drain("drain_up", 200);
        check("up_ready", int'(req_ready), 1);
        check("up_vreg", int'(vreg_level), 6);
        check("up_freq", int'(freq_level), 6);

        // lower 6/6 -> 2/2, frequency first
        c0 = cyc;
        expect_ev(EV_F, 2, c0 + 1);
        expect_ev(EV_V, 2, c0 + 5);
        expect_ev(EV_D, 0, c0 + 74);
        issue(2, 2);
        pulse_fack(c0 + 4);
        pulse_vack(c0 + 8);
        drain("drain_down", 200);
        check("down_vreg", int'(vreg_level), 2);

        // V below F is lifted to F
        do_reset();
        c0 = cyc;
        expect_ev(EV_V, 5, c0 + 1);
        expect_ev(EV_F, 5, c0 + 68);
        expect_ev(EV_D, 0, c0 + 72);
        issue(1, 5);
        pulse_vack(c0 + 3);
        pulse_fack(c0 + 70);
        drain("drain_vmax", 200);

        // ack timeout -> fault, then clear
        c0 = cyc;
        expect_ev(EV_V, 7, c0 + 1);
        issue(7, 7);
        wait_until(c0 + 1025);
        check("fault_before_timeout", int'(fault), 0);
        step();
        check("fault_set", int'(fault), 1);
        check("fault_busy", int'(busy), 1);
        check("fault_ready", int'(req_ready), 0);
        req_valid = 1'b1;
        vreg_ack  = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("fault_sticky", int'(fault), 1);
        req_valid   = 1'b0;
        vreg_ack    = 1'b0;
        fault_clear = 1'b1;
        step();
        fault_clear = 1'b0;
        check("fault_cleared", int'(fault), 0);
        check("fault_idle", int'(busy), 0);
        check("fault_vreg_kept", int'(vreg_level), 7);
        check("fault_freq_kept", int'(freq_level), 5);
        drain("drain_fault", 4);

        // thermal alert mid-transition, override follows
        do_reset();
        c0 = cyc;
        expect_ev(EV_V, 6, c0 + 1);
        expect_ev(EV_F, 6, c0 + 70);
        expect_ev(EV_D, 0, c0 + 74);
        expect_ev(EV_F, 1, c0 + 75);
        expect_ev(EV_V, 1, c0 + 78);
        expect_ev(EV_D, 0, c0 + 146);
        issue(6, 6);
        req_valid         = 1'b1;
        req_voltage_level = 3'd7;
        req_freq_level    = 3'd7;
        wait_until(c0 + 3);
        thermal_alert = 1'b1;
        step();
        thermal_alert = 1'b0;
        pulse_vack(c0 + 5);
        pulse_fack(c0 + 72);
        wait_until(c0 + 74);
        check("pending_blocks_ready", int'(req_ready), 0);
        pulse_fack(c0 + 77);
        req_valid = 1'b0;
        pulse_vack(c0 + 80);
        drain("drain_thermal", 200);
        check("therm_vreg", int'(vreg_level), 1);
        check("therm_freq", int'(freq_level), 1);

        // alert at thermal level: skipped, no done
        thermal_alert = 1'b1;
        #1;
        check("alert_blocks_ready", int'(req_ready), 0);
        step();
        thermal_alert = 1'b0;
        #1;
        check("skip_ready", int'(req_ready), 1);
        for (int i = 0; i < 4; i++) step();
        check("skip_busy", int'(busy), 0);
        check("skip_no_events", int'(evq.size()), 0);

        // equal request, then reset during settle
        do_reset();
        c0 = cyc;
        expect_ev(EV_D, 0, c0 + 2);
        issue(4, 4);
        drain("drain_equal", 10);
        c0 = cyc;
        expect_ev(EV_V, 6, c0 + 1);
        issue(6, 6);
        pulse_vack(c0 + 3);
        wait_until(c0 + 10);
        check("settle_busy", int'(busy), 1);
        rst = 1'b1;
        step();
        check("midrst_vreg", int'(vreg_level), 4);
        check("midrst_freq", int'(freq_level), 4);
        check("midrst_busy", int'(busy), 0);
        check("midrst_upd", int'(vreg_update), 0);
        rst = 1'b0;
        step();
        step();
        check("midrst_no_events", int'(evq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
